// File: rtl/axi_lite_regfile_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile_slave
//
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers starting at
// byte address BASE_ADDR. The write and read channels are independent.
//
// Write side: a four-state FSM accepts AW and W in either order, or in the
// same cycle. Whichever arrives first is held in a register. The register
// file is updated on the edge that completes the second handshake. The
// response is then held on B until bready is seen.
//
// Read side: there is one outstanding read at a time. arready is high exactly
// when no read data is pending. Data appears one cycle after the AR handshake
// and is held until rready is seen.
//
// Parameters
//   ADDR_WIDTH  address bus width in bits (default 32)
//   NUM_REGS    number of 32-bit registers, power of two, 2..256 (default 16)
//   BASE_ADDR   byte address of register 0, NUM_REGS*4 aligned
//
// Ports
//   aclk, areset                  clock, synchronous active-high reset
//   awaddr/awvalid/awready        write address channel
//   wdata/wstrb/wvalid/wready     write data channel
//   bresp/bvalid/bready           write response channel
//   araddr/arvalid/arready        read address channel
//   rdata/rresp/rvalid/rready     read data channel
//
// Build option
//   SLV_DECERR_EN  When defined, out-of-range accesses return SLVERR (2'b10).
//                  Otherwise they return OKAY. In both cases an out-of-range
//                  write is dropped and an out-of-range read returns zero.
// -----------------------------------------------------------------------------
module axi_lite_regfile_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int                    IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [1:0]            RESP_OKAY  = 2'b00;
`ifdef SLV_DECERR_EN
    localparam logic [1:0]            RESP_OOR   = 2'b10;
`else
    localparam logic [1:0]            RESP_OOR   = 2'b00;
`endif

    typedef enum logic [1:0] {
        W_IDLE,
        W_GOT_ADDR,
        W_GOT_DATA,
        W_RESP
    } w_state_t;

    // ------------------------------------------------------------------ state
    w_state_t              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;

    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [31:0]           regs_q [NUM_REGS];
    logic [31:0]           regs_d [NUM_REGS];

    // ------------------------------------------------------------- handshakes
    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = awvalid & awready_q;
    assign w_hs  = wvalid  & wready_q;
    assign ar_hs = arvalid & arready_q;

    // ----------------------------------------------------------- write decode
    // Where one half was captured earlier, the held copy is used. Otherwise
    // the live bus value is used, because it completes on this edge.
    logic [ADDR_WIDTH-1:0] wr_addr, wr_off;
    logic [31:0]           wr_data, wr_old, wr_merged;
    logic [3:0]            wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic                  wr_in_range;
    logic                  wr_fire;

    assign wr_addr     = (w_state_q == W_GOT_ADDR) ? awaddr_q : awaddr;
    assign wr_data     = (w_state_q == W_GOT_DATA) ? wdata_q  : wdata;
    assign wr_strb     = (w_state_q == W_GOT_DATA) ? wstrb_q  : wstrb;
    assign wr_off      = wr_addr - BASE_ADDR;
    assign wr_in_range = (wr_addr >= BASE_ADDR) && ((wr_off >> 2) < NUM_REGS_A);
    assign wr_idx      = wr_off[IDX_W+1:2];
    assign wr_old      = regs_q[wr_idx];

    // Byte-lane merge of new data over the current register contents.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wr_merged[gi*8 +: 8] = wr_strb[gi] ? wr_data[gi*8 +: 8] : wr_old[gi*8 +: 8];
    end

    // ------------------------------------------------------------ read decode
    logic [ADDR_WIDTH-1:0] rd_off;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_in_range;

    assign rd_off      = araddr - BASE_ADDR;
    assign rd_in_range = (araddr >= BASE_ADDR) && ((rd_off >> 2) < NUM_REGS_A);
    assign rd_idx      = rd_off[IDX_W+1:2];

    // ---------------------------------------------------------- write FSM
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        wr_fire   = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_fire   = 1'b1;
                    w_state_d = W_RESP;
                end else if (aw_hs) begin
                    awaddr_d  = awaddr;
                    w_state_d = W_GOT_ADDR;
                end else if (w_hs) begin
                    wdata_d   = wdata;
                    wstrb_d   = wstrb;
                    w_state_d = W_GOT_DATA;
                end
            end
            W_GOT_ADDR: begin
                if (w_hs) begin
                    wr_fire   = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_GOT_DATA: begin
                if (aw_hs) begin
                    wr_fire   = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        if (wr_fire) begin
            bresp_d = wr_in_range ? RESP_OKAY : RESP_OOR;
        end

        // The ready and valid outputs are registered. They are derived from
        // the next state, so they line up with the state they describe.
        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_GOT_DATA);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_GOT_ADDR);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // ------------------------------------------------------- register update
    always_comb begin
        regs_d = regs_q;
        if (wr_fire && wr_in_range) begin
            regs_d[wr_idx] = wr_merged;
        end
    end

    // -------------------------------------------------------------- read path
    // rdata_d samples regs_q, not regs_d. A read and a write of the same
    // register completing on the same edge therefore return the old value.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_in_range ? regs_q[rd_idx] : 32'h0;
            rresp_d  = rd_in_range ? RESP_OKAY : RESP_OOR;
        end

        arready_d = ~rvalid_d;
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            regs_q    <= '{default: '0};
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_regfile_slave
//
// Directed test of axi_lite_regfile_slave with its default parameters
// (32-bit address, 16 registers, base address 0). Inputs are driven 1 ns after
// the rising edge, and outputs are sampled at that same point. Each expected
// value is written out by hand in the vector that uses it.
// -----------------------------------------------------------------------------
module tb_axi_lite_regfile_slave;

    localparam int ADDR_WIDTH = 32;
`ifdef SLV_DECERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic                  aclk;
    logic                  areset;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    int n_vec  = 0;
    int n_miss = 0;

    axi_lite_regfile_slave #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (16),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // AW and W are presented in the same cycle with bready=1.
    // bvalid is expected one cycle later and cleared on the next edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        awaddr  = addr;
        awvalid = 1'b1;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        bready  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("wr_bvalid", 32'(bvalid), 32'd1);
        check("wr_bresp", 32'(bresp), 32'(exp_resp));
        $display("write addr=%h data=%h strb=%b bresp=%b", addr, data, strb, bresp);
        tick();
        bready = 1'b0;
        check("wr_bvalid_clr", 32'(bvalid), 32'd0);
        check("wr_awready_back", 32'(awready), 32'd1);
    endtask

    // Read one address. The data is held for one extra cycle with rready=0
    // to confirm that it stays stable.
    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b0;
        tick();
        arvalid = 1'b0;
        check("rd_rvalid", 32'(rvalid), 32'd1);
        check("rd_rdata", rdata, exp_data);
        check("rd_rresp", 32'(rresp), 32'(exp_resp));
        check("rd_arready_busy", 32'(arready), 32'd0);
        $display("read  addr=%h rdata=%h rresp=%b", addr, rdata, rresp);
        tick();
        check("rd_rdata_hold", rdata, exp_data);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rd_rvalid_clr", 32'(rvalid), 32'd0);
        check("rd_arready_back", 32'(arready), 32'd1);
    endtask

    initial begin
        areset  = 1'b1;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        areset = 1'b0;
        tick();
        check("rel_awready", 32'(awready), 32'd1);
        check("rel_wready", 32'(wready), 32'd1);
        check("rel_arready", 32'(arready), 32'd1);

        // AW and W in the same cycle, then read back
        axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, 2'b00);
        axi_read(32'h04, 32'hDEAD_BEEF, 2'b00);

        // W two cycles before AW, strobe 0101, over 0 -> 0x00220044
        wdata  = 32'h1122_3344;
        wstrb  = 4'b0101;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("gotdata_awready", 32'(awready), 32'd1);
        check("gotdata_wready", 32'(wready), 32'd0);
        tick();
        awaddr  = 32'h08;
        awvalid = 1'b1;
        bready  = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_bvalid", 32'(bvalid), 32'd1);
        check("wfirst_bresp", 32'(bresp), 32'd0);
        $display("write addr=08 data=11223344 strb=0101 (W first) bresp=%b", bresp);
        tick();
        bready = 1'b0;
        axi_read(32'h08, 32'h0022_0044, 2'b00);

        // AW one cycle before W
        awaddr  = 32'h0C;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("gotaddr_awready", 32'(awready), 32'd0);
        check("gotaddr_wready", 32'(wready), 32'd1);
        wdata  = 32'hA5A5_5A5A;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        bready = 1'b1;
        tick();
        wvalid = 1'b0;
        check("afirst_bvalid", 32'(bvalid), 32'd1);
        $display("write addr=0c data=a5a55a5a strb=1111 (AW first) bresp=%b", bresp);
        tick();
        bready = 1'b0;
        axi_read(32'h0C, 32'hA5A5_5A5A, 2'b00);

        // Response held for 5 cycles. A competing AW/W must not be accepted.
        awaddr  = 32'h14;
        wdata   = 32'h1234_5678;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b0;
        tick();
        awaddr = 32'h18;
        wdata  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid", 32'(bvalid), 32'd1);
            check("stall_bresp", 32'(bresp), 32'd0);
            check("stall_awready", 32'(awready), 32'd0);
            check("stall_wready", 32'(wready), 32'd0);
            tick();
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        tick();
        bready = 1'b0;
        check("stall_bvalid_clr", 32'(bvalid), 32'd0);
        $display("write addr=14 data=12345678 released after 5 stall cycles");
        axi_read(32'h14, 32'h1234_5678, 2'b00);
        axi_read(32'h18, 32'h0, 2'b00);

        // wstrb=0 changes nothing; addr[1:0] is ignored
        axi_write(32'h04, 32'h0000_0000, 4'b0000, 2'b00);
        axi_read(32'h07, 32'hDEAD_BEEF, 2'b00);

        // Last register, then out-of-range accesses
        axi_write(32'h3C, 32'h0F0F_0F0F, 4'hF, 2'b00);
        axi_read(32'h3C, 32'h0F0F_0F0F, 2'b00);
        axi_write(32'h40, 32'hCAFE_F00D, 4'hF, OOR);
        axi_read(32'h40, 32'h0, OOR);
        axi_read(32'h00, 32'h0, 2'b00);
        axi_read(32'h3C, 32'h0F0F_0F0F, 2'b00);

        // Read and write of the same register on the same edge
        awaddr  = 32'h14;
        wdata   = 32'hAAAA_5555;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        araddr  = 32'h14;
        arvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        check("same_rdata_old", rdata, 32'h1234_5678);
        check("same_rvalid", 32'(rvalid), 32'd1);
        check("same_bvalid", 32'(bvalid), 32'd1);
        $display("concurrent write/read addr=14 rdata=%h", rdata);
        bready = 1'b1;
        rready = 1'b1;
        tick();
        bready = 1'b0;
        rready = 1'b0;
        check("same_bvalid_clr", 32'(bvalid), 32'd0);
        check("same_rvalid_clr", 32'(rvalid), 32'd0);
        axi_read(32'h14, 32'hAAAA_5555, 2'b00);

        // Reset while in W_GOT_ADDR
        awaddr  = 32'h20;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wdata   = 32'h7777_7777;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        areset  = 1'b1;
        tick();
        check("midrst_awready", 32'(awready), 32'd0);
        check("midrst_bvalid", 32'(bvalid), 32'd0);
        areset = 1'b0;
        wvalid = 1'b0;
        tick();
        check("postrst_awready", 32'(awready), 32'd1);
        check("postrst_wready", 32'(wready), 32'd1);
        check("postrst_bvalid", 32'(bvalid), 32'd0);
        $display("reset in W_GOT_ADDR released");
        axi_read(32'h20, 32'h0, 2'b00);
        axi_read(32'h04, 32'h0, 2'b00);

        // A fresh W-first write after reset lands at the new address only
        wdata  = 32'h0BAD_CAFE;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        tick();
        wvalid  = 1'b0;
        awaddr  = 32'h24;
        awvalid = 1'b1;
        bready  = 1'b1;
        tick();
        awvalid = 1'b0;
        check("postrst_wr_bvalid", 32'(bvalid), 32'd1);
        tick();
        bready = 1'b0;
        axi_read(32'h24, 32'h0BAD_CAFE, 2'b00);
        axi_read(32'h20, 32'h0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
